arb_requester: RTL
==================

ARB_REQUESTER -- requirements
Module: arb_requester

Interface
REQ-001 Parameter DATA_W, default 8: width of beat data.
REQ-002 Parameter LEN_W, default 4: width of cmd_len; max burst 2^LEN_W beats.
REQ-003 Parameter TIMEOUT, default 64: grant-wait limit in cycles; used only with the timeout feature compiled in.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 nreset  in  1  asynchronous, active-low reset.
REQ-006 cmd_valid  in  1  client presents a burst command.
REQ-007 cmd_ready  out  1  block accepts a command.
REQ-008 cmd_len  in  LEN_W  burst length minus one.
REQ-009 wdata_valid  in  1  client beat data valid.
REQ-010 wdata  in  DATA_W  client beat data.
REQ-011 wdata_ready  out  1  beat consumed this cycle.
REQ-012 req  out  1  request to arbiter (drives arbiter req_N).
REQ-013 gnt  in  1  grant from arbiter (from arbiter gnt_N).
REQ-014 bus_valid  out  1  beat driven on shared bus.
REQ-015 bus_data  out  DATA_W  beat data.
REQ-016 bus_last  out  1  final beat of burst.
REQ-017 err_timeout  out  1  one-cycle pulse on grant timeout.

Function
REQ-018 FSM states IDLE, REQ, XFER, REL; the FSM SHALL be encoded in a registered state vector.
REQ-019 IDLE: cmd_ready=1; on cmd_valid&cmd_ready, latch cmd_len into beat counter and go to REQ; req rises the following cycle.
REQ-020 REQ: req=1; on gnt=1 go to XFER next cycle; no beat is transferred in REQ.
REQ-021 XFER: req=1; bus_valid=wdata_ready=gnt&wdata_valid; bus_data=wdata combinationally; counter decrements per beat.
REQ-022 bus_last SHALL be 1 with bus_valid when counter==0; that beat moves the FSM to REL.
REQ-023 REL: req=0, cmd_ready=0 for exactly one cycle, then IDLE; guarantees the arbiter sees req low between bursts.
REQ-024 gnt low during XFER: stall, bus_valid=0, req held, counter frozen; resume when gnt returns.
REQ-025 wdata_valid low during XFER: bus_valid=0, req held, counter frozen.
REQ-026 cmd_len=0: single beat with bus_last=1.
REQ-027 cmd_len=all-ones: exactly 2^LEN_W beats; counter SHALL NOT wrap before bus_last.
REQ-028 cmd_valid outside IDLE SHALL be ignored (not queued).
REQ-029 gnt high in IDLE or REL SHALL be ignored; no bus_valid.

Reset
REQ-030 nreset low SHALL immediately force state=IDLE, req=0, bus_valid=0, bus_last=0, wdata_ready=0, err_timeout=0, counter=0, bus_data=0; cmd_ready=1 once in IDLE.
REQ-031 Reset mid-burst SHALL abandon the burst with no further beats after release.

Configuration
REQ-032 Macro ARB_REQ_TIMEOUT_EN defined: a wait counter SHALL count cycles in REQ with gnt=0; reaching TIMEOUT SHALL pulse err_timeout for one cycle, drop the command and go to REL.
REQ-033 Macro undefined: REQ waits indefinitely; err_timeout port SHALL remain and be tied to 0.

Structure
REQ-034 Shared package arb_req_pkg SHALL hold the state enumeration and state-width localparam.
REQ-035 Timeout counter SHALL be sub-module arb_req_wdog, instantiated only under ARB_REQ_TIMEOUT_EN.

Verification
REQ-036 Reset asserted at t=0, released -> req=0, bus_valid=0, cmd_ready=1.
REQ-037 cmd_len=3, gnt one cycle after req, wdata_valid=1, data 0xA0..0xA3 -> 4 beats, bus_last on 0xA3, then req=0 for one cycle.
REQ-038 cmd_len=2, gnt dropped for 2 cycles after beat 1 -> bus_valid=0 during gap, req held, 3 beats total, order preserved.
REQ-039 cmd_len=0 with wdata_valid toggling 0,1 -> single beat with bus_last=1 on the first cycle both gnt and wdata_valid are 1.
REQ-040 nreset pulsed low during beat 2 of cmd_len=5 -> req and bus_valid 0 immediately; after release, IDLE with cmd_ready=1.
REQ-041 ARB_REQ_TIMEOUT_EN, TIMEOUT=8, gnt held 0 -> err_timeout pulses once after 8 REQ cycles, req=0 next cycle, no beats; without macro, req stays 1.

Source files
------------

// File: rtl/arb_req_pkg.sv
// arb_req_pkg: shared types for the arbiter requester.
// Holds the burst FSM state enumeration and its width.
package arb_req_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2,
    ST_REL  = 2'd3
  } state_e;

  localparam int BEAT_DW = 8;
  localparam int BEAT_LW = 4;

endpackage

// File: rtl/arb_requester_if.sv
// arb_requester_if: client command/beat side plus arbiter and bus side.
// master = requester block, slave = client/arbiter/bus environment.
interface arb_requester_if #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [LEN_W-1:0]  cmd_len;
  logic              wdata_valid;
  logic [DATA_W-1:0] wdata;
  logic              wdata_ready;
  logic              req;
  logic              gnt;
  logic              bus_valid;
  logic [DATA_W-1:0] bus_data;
  logic              bus_last;
  logic              err_timeout;

  modport master (
    input  cmd_valid,
    input  cmd_len,
    input  wdata_valid,
    input  wdata,
    input  gnt,
    output cmd_ready,
    output wdata_ready,
    output req,
    output bus_valid,
    output bus_data,
    output bus_last,
    output err_timeout
  );

  modport slave (
    output cmd_valid,
    output cmd_len,
    output wdata_valid,
    output wdata,
    output gnt,
    input  cmd_ready,
    input  wdata_ready,
    input  req,
    input  bus_valid,
    input  bus_data,
    input  bus_last,
    input  err_timeout
  );

endinterface

// File: rtl/arb_req_wdog.sv
// arb_req_wdog: grant-wait watchdog for the requester.
// Counts enabled cycles; expire is high on the TIMEOUT-th one.
module arb_req_wdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic nreset,
  input  logic en,
  input  logic clr,
  output logic expire
);

  localparam int CW =
    (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [CW-1:0] LAST =
    CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign expire = en & (cnt_q == LAST);

  // next wait count: restart outside the wait or on expiry
  always_comb begin
    cnt_d = cnt_q;
    unique case (1'b1)
      clr | expire: cnt_d = '0;
      en:           cnt_d = cnt_q + CW'(1);
      default:      cnt_d = cnt_q;
    endcase
  end

  // wait count register
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/arb_requester.sv
// arb_requester: bursts client beats onto a shared bus under arbitration.
// Optional grant timeout with ARB_REQ_TIMEOUT_EN (wdog sub-module).
module arb_requester
  import arb_req_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic nreset,
  arb_requester_if.master bus
);

  state_e state_q;
  state_e state_d;

  logic [LEN_W-1:0]  cnt_q;
  logic [LEN_W-1:0]  cnt_d;
  logic [DATA_W-1:0] data_o;

  logic beat;
  logic cnt_zero;
  logic to_fire;

  assign cnt_zero = (cnt_q == '0);

`ifdef ARB_REQ_TIMEOUT_EN
  logic wd_en;
  logic wd_clr;

  assign wd_en  = (state_q == ST_REQ) & ~bus.gnt;
  assign wd_clr = (state_q != ST_REQ);

  arb_req_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk    (clk),
    .nreset (nreset),
    .en     (wd_en),
    .clr    (wd_clr),
    .expire (to_fire)
  );
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT > 0);
  assign to_fire = 1'b0;
`endif

  assign bus.err_timeout = to_fire;
  assign bus.bus_data    = data_o;

  // next state, beat counter and handshake outputs
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    beat            = 1'b0;
    data_o          = '0;
    bus.cmd_ready   = 1'b0;
    bus.req         = 1'b0;
    bus.bus_valid   = 1'b0;
    bus.wdata_ready = 1'b0;
    bus.bus_last    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          cnt_d   = bus.cmd_len;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        bus.req = 1'b1;
        if (bus.gnt) begin
          state_d = ST_XFER;
        end else if (to_fire) begin
          cnt_d   = '0;
          state_d = ST_REL;
        end
      end
      ST_XFER: begin
        bus.req         = 1'b1;
        beat            = bus.gnt & bus.wdata_valid;
        bus.bus_valid   = beat;
        bus.wdata_ready = beat;
        bus.bus_last    = beat & cnt_zero;
        data_o          = bus.wdata;
        if (beat) begin
          if (cnt_zero) begin
            state_d = ST_REL;
          end else begin
            cnt_d = cnt_q - LEN_W'(1);
          end
        end
      end
      ST_REL: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // state and beat counter registers
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
